// File: rtl/fetch_pkg.sv
// Shared types and constants for the fetch stage: FSM states, default widths,
// the done opcode and the entry points of the resident programs.
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int FETCH_PW = 9;
  localparam int FETCH_OW = 15;
  localparam int FETCH_CW = 16;

  localparam logic [4:0] OP_DONE = 5'b01110;

  localparam logic [8:0] PROG_PRODUCT  = 9'd1;
  localparam logic [8:0] PROG_STRMATCH = 9'd25;
  localparam logic [8:0] PROG_CLOSEST  = 9'd42;

endpackage

// File: rtl/fetch_ctrl_branch_target.sv
// Combinational PC-relative target: iptr + sext(off), truncated to PW bits.
module branch_target #(
  parameter int PW = 9,
  parameter int OW = 15
) (
  input  logic [PW-1:0] iptr_i,
  input  logic [OW-1:0] off_i,
  output logic [PW-1:0] target_o
);

  generate
    if (OW > PW) begin : g_trunc
      // Offset bits above PW only affect address bits that get truncated away.
      logic unused_off_hi;
      assign unused_off_hi = ^off_i[OW-1:PW];
      assign target_o      = iptr_i + off_i[PW-1:0];
    end else begin : g_sext
      logic [PW-1:0] off_ext;
      assign off_ext  = PW'($signed(off_i));
      assign target_o = iptr_i + off_ext;
    end
  endgenerate

endmodule

// File: rtl/fetch_ctrl.sv
// Program counter / fetch sequencer feeding the instruction ROM (IDLE/RUN/DONE).
// Optional RUN-cycle counter enabled by defining FETCH_CYCLE_COUNT_EN.
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter int PW = FETCH_PW,
  parameter int OW = FETCH_OW,
  parameter int CW = FETCH_CW
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          Start,
  input  logic [PW-1:0] StartAddr,
  input  logic          Halt,
  input  logic          Stall,
  input  logic          BranchEn,
  input  logic [OW-1:0] BranchOff,
  output logic [PW-1:0] Iptr,
  output logic          Running,
  output logic          Done,
  output logic [CW-1:0] CycleCount
);

  state_t        state_q;
  logic [PW-1:0] iptr_q;
  logic [PW-1:0] iptr_d;
  logic [PW-1:0] target;
  logic          running_q;
  logic          done_q;
  logic          launch;

  branch_target #(
    .PW(PW),
    .OW(OW)
  ) u_branch_target (
    .iptr_i  (iptr_q),
    .off_i   (BranchOff),
    .target_o(target)
  );

  // Advance address when neither halted nor stalled; wraps modulo 2**PW.
  always_comb begin
    iptr_d = iptr_q + PW'(1);
    if (BranchEn) begin
      iptr_d = target;
    end
  end

  assign launch = Start && (state_q != RUN);

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q   <= IDLE;
      iptr_q    <= '0;
      running_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      case (state_q)
        RUN: begin
          if (Halt) begin
            state_q   <= DONE;
            running_q <= 1'b0;
            done_q    <= 1'b1;
          end else if (!Stall) begin
            iptr_q <= iptr_d;
          end
        end
        DONE: begin
          if (Start) begin
            state_q   <= RUN;
            iptr_q    <= StartAddr;
            running_q <= 1'b1;
            done_q    <= 1'b0;
          end
        end
        default: begin
          iptr_q <= '0;
          if (Start) begin
            state_q   <= RUN;
            iptr_q    <= StartAddr;
            running_q <= 1'b1;
            done_q    <= 1'b0;
          end
        end
      endcase
    end
  end

`ifdef FETCH_CYCLE_COUNT_EN
  logic [CW-1:0] cnt_q;

  // Counts every RUN cycle (stall and halt cycles included), saturating.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      cnt_q <= '0;
    end else if (launch) begin
      cnt_q <= '0;
    end else if ((state_q == RUN) && (cnt_q != {CW{1'b1}})) begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

  assign CycleCount = cnt_q;
`else
  logic unused_launch;
  assign unused_launch = launch;
  assign CycleCount    = '0;
`endif

  assign Iptr    = iptr_q;
  assign Running = running_q;
  assign Done    = done_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Scoreboard bench for fetch_ctrl: each driven cycle queues its expected outputs,
// which are popped and compared one time unit after the following rising edge.
module tb_fetch_ctrl;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        Start;
  logic [8:0]  StartAddr;
  logic        Halt;
  logic        Stall;
  logic        BranchEn;
  logic [14:0] BranchOff;
  logic [8:0]  Iptr;
  logic        Running;
  logic        Done;
  logic [15:0] CycleCount;

  typedef struct packed {
    logic [8:0]  iptr;
    logic        run;
    logic        done;
    logic [15:0] cnt;
  } exp_t;

  exp_t sb_q[$];
  int   tests_run = 0;
  int   tests_failed = 0;

  fetch_ctrl #(.PW(9), .OW(15), .CW(16)) dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .Start     (Start),
    .StartAddr (StartAddr),
    .Halt      (Halt),
    .Stall     (Stall),
    .BranchEn  (BranchEn),
    .BranchOff (BranchOff),
    .Iptr      (Iptr),
    .Running   (Running),
    .Done      (Done),
    .CycleCount(CycleCount)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] exp_c(input int v);
`ifdef FETCH_CYCLE_COUNT_EN
    return 16'(v);
`else
    return 16'(v * 0);
`endif
  endfunction

  // Drive one cycle of inputs, queue the expectation, then compare after the edge.
  task automatic cyc(input string tag, input logic rst, input logic st, input logic [8:0] addr,
                     input logic hl, input logic sl, input logic br, input logic [14:0] off,
                     input logic [8:0] e_iptr, input logic e_run, input logic e_done,
                     input int e_cnt);
    exp_t e;
    Reset     = rst;
    Start     = st;
    StartAddr = addr;
    Halt      = hl;
    Stall     = sl;
    BranchEn  = br;
    BranchOff = off;
    e.iptr = e_iptr;
    e.run  = e_run;
    e.done = e_done;
    e.cnt  = exp_c(e_cnt);
    sb_q.push_back(e);
    @(posedge Clk);
    #1;
    if (sb_q.size() == 0) begin
      check({tag, ".sb_empty"}, 32'd0, 32'd1);
    end else begin
      e = sb_q.pop_front();
      check({tag, ".iptr"}, 32'(Iptr), 32'(e.iptr));
      check({tag, ".run"},  32'(Running), 32'(e.run));
      check({tag, ".done"}, 32'(Done), 32'(e.done));
      check({tag, ".cnt"},  32'(CycleCount), 32'(e.cnt));
    end
  endtask

  initial begin
    //   tag          rst st addr  hl sl br off        iptr   run done cnt
    cyc("reset",      1, 0, 9'd0,  0, 0, 0, 15'd0,     9'd0,  0, 0, 0);
    cyc("idle_ign",   0, 0, 9'd7,  1, 1, 1, 15'd5,     9'd0,  0, 0, 0);
    cyc("start1",     0, 1, 9'd1,  0, 0, 0, 15'd0,     9'd1,  1, 0, 0);
    cyc("seq2",       0, 0, 9'd0,  0, 0, 0, 15'd0,     9'd2,  1, 0, 1);
    cyc("seq3",       0, 0, 9'd0,  0, 0, 0, 15'd0,     9'd3,  1, 0, 2);
    cyc("seq4",       0, 0, 9'd0,  0, 0, 0, 15'd0,     9'd4,  1, 0, 3);
    cyc("seq5",       0, 0, 9'd0,  0, 0, 0, 15'd0,     9'd5,  1, 0, 4);
    cyc("br_p4",      0, 0, 9'd0,  0, 0, 1, 15'd4,     9'd9,  1, 0, 5);
    cyc("br_p7",      0, 0, 9'd0,  0, 0, 1, 15'd7,     9'h10, 1, 0, 6);
    cyc("br_m14",     0, 0, 9'd0,  0, 0, 1, 15'h7FF2,  9'h02, 1, 0, 7);
    cyc("br_zero",    0, 0, 9'd0,  0, 0, 1, 15'd0,     9'h02, 1, 0, 8);
    cyc("br_one",     0, 0, 9'd0,  0, 0, 1, 15'd1,     9'd3,  1, 0, 9);
    cyc("br_wrap",    0, 0, 9'd0,  0, 0, 1, 15'h7FF2,  9'd501, 1, 0, 10);
    cyc("start_run",  0, 1, 9'd200,0, 0, 0, 15'd0,     9'd502, 1, 0, 11);
    cyc("br_to7",     0, 0, 9'd0,  0, 0, 1, 15'h7E11,  9'd7,  1, 0, 12);
    cyc("stall_br",   0, 0, 9'd0,  0, 1, 1, 15'd5,     9'd7,  1, 0, 13);
    cyc("stall",      0, 0, 9'd0,  0, 1, 0, 15'd0,     9'd7,  1, 0, 14);
    cyc("br_3b",      0, 0, 9'd0,  0, 0, 1, 15'd52,    9'h3B, 1, 0, 15);
    cyc("halt",       0, 0, 9'd0,  1, 0, 1, 15'd3,     9'h3B, 0, 1, 16);
    cyc("done_ign",   0, 0, 9'd0,  1, 1, 1, 15'd3,     9'h3B, 0, 1, 16);
    cyc("restart25",  0, 1, 9'd25, 0, 0, 0, 15'd0,     9'd25, 1, 0, 0);
    cyc("seq26",      0, 0, 9'd0,  0, 0, 0, 15'd0,     9'd26, 1, 0, 1);
    cyc("start_ign",  0, 1, 9'd1,  0, 0, 0, 15'd0,     9'd27, 1, 0, 2);
    cyc("halt2",      0, 0, 9'd0,  1, 1, 0, 15'd0,     9'd27, 0, 1, 3);
    cyc("start511",   0, 1, 9'd511,0, 0, 0, 15'd0,     9'd511, 1, 0, 0);
    cyc("wrap0",      0, 0, 9'd0,  0, 0, 0, 15'd0,     9'd0,  1, 0, 1);
    cyc("seq1b",      0, 0, 9'd0,  0, 0, 0, 15'd0,     9'd1,  1, 0, 2);
    cyc("br_42",      0, 0, 9'd0,  0, 0, 1, 15'd41,    9'd42, 1, 0, 3);
    cyc("reset_mid",  1, 1, 9'd9,  1, 0, 1, 15'd3,     9'd0,  0, 0, 0);
    cyc("idle_after", 0, 0, 9'd0,  0, 0, 0, 15'd0,     9'd0,  0, 0, 0);

    // Long run from address 0 to exercise counter saturation and PC wrap.
    cyc("sat_start",  0, 1, 9'd0,  0, 0, 0, 15'd0,     9'd0,  1, 0, 0);
    for (int n = 1; n <= 65540; n++) begin
      cyc("sat", 0, 0, 9'd0, 0, 0, 0, 15'd0, 9'(n % 512), 1, 0, (n > 65535) ? 65535 : n);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
